branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised, fully-associative branch target buffer with saturating direction counters for the superscalar fetch stage. It looks up every slot of a FETCH_WIDTH-wide fetch group in one cycle and returns the first predicted-taken slot and its target. It also learns from resolved branches (BEQ/BNE/BLT/BGE/J/JAL) reported by the execute stage, so back-to-back branches in one fetch group are steered without a bubble.

## Interface
- ENTRIES, 16: number of BTB entries, ≥2.
- FETCH_WIDTH, 2: instructions per fetch group, ≥1.
- ADDR_W, 10: instruction word-address width; tag is the full PC.
- CTR_W, 2: direction counter width, ≥1.
- clk1  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- fetch_valid  input  1  fetch group present this cycle.
- fetch_pc  input  ADDR_W  word address of slot 0; slot k is fetch_pc+k, modulo 2^ADDR_W.
- pred_taken  output  1  some slot is predicted taken.
- pred_slot  output  max(1,clog2(FETCH_WIDTH))  lowest predicted-taken slot index.
- pred_target  output  ADDR_W  target for pred_slot.
- upd_valid  input  1  resolved branch report.
- upd_pc  input  ADDR_W  PC of the resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  ADDR_W  actual target; meaningful only when upd_taken=1.
- flush  input  1  synchronous invalidate-all.

## Operation
- Entry state: valid, tag[ADDR_W], target[ADDR_W], ctr[CTR_W]. There is also a victim pointer, vptr, with clog2(ENTRIES) bits.
- Lookup is combinational from registered state:
  - Slot k hits when some valid entry has tag == fetch_pc+k.
  - A hit predicts taken when the MSB of that entry's ctr is 1.
  - pred_taken, pred_slot and pred_target come from the lowest such k.
  - With fetch_valid=0 or no taken hit, all three outputs are 0.
- Tags are unique; update never allocates a duplicate.
- Update on hit (upd_valid=1, matching entry):
  - upd_taken=1: ctr saturating-increments to a maximum of 2^CTR_W-1, and target is overwritten with upd_target.
  - upd_taken=0: ctr saturating-decrements to a minimum of 0, and target is unchanged.
- Update on miss:
  - upd_taken=0: no change.
  - upd_taken=1: allocate an entry with valid=1, tag=upd_pc, target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
  - Allocation takes the lowest-index invalid entry when one exists; vptr is unchanged.
  - Otherwise allocation replaces entry vptr, and vptr advances by 1, wrapping from ENTRIES-1 to 0.
- flush=1: all valid bits go to 0 and vptr goes to 0. Targets and counters are don't-care.
- flush and upd_valid in the same cycle: flush wins and the update is dropped.
- Lookup and update to the same PC in the same cycle: lookup reflects pre-update state.

## Timing
- Prediction latency is 0 cycles (combinational from fetch_pc).
- An update is visible to lookup in the cycle after the posedge that samples it.
- Reset values:
  - all valid=0, vptr=0, counters=2^(CTR_W-1), targets and tags=0.
  - pred_taken=0, pred_slot=0, pred_target=0.
- Asserting reset mid-operation clears state immediately. The first lookup after reset is released always misses.
- No handshake: one update is accepted per cycle, every cycle.

## Test plan
- Reset, then fetch_valid=1, fetch_pc=8 -> pred_taken=0, pred_slot=0, pred_target=0. Repeat with fetch_valid=0 after training -> outputs 0.
- Update pc=8, taken, target=20; next cycle fetch_pc=8 -> pred_taken=1, slot 0, target 20. Then fetch_pc=7 -> slot 1, target 20.
- Counter walk on pc=8 (CTR_W=2, ctr starting at 2):
  - not-taken, not-taken -> ctr 1 then 0; pred_taken=0 after the first.
  - taken once -> ctr 1, still 0; taken again -> ctr 2, pred_taken=1.
  - taken ×4 -> ctr 3 (saturated); one not-taken -> ctr 2, still taken.
- Back-to-back branches:
  - Train pc=8→20 and pc=9→18; fetch_pc=8 -> slot 0, target 20.
  - Train pc=8 not-taken ×2 -> slot 1, target 18.
  - Update pc=9 taken with target 25 -> target 25 next cycle.
- Capacity (ENTRIES=16):
  - Allocate taken pcs 100..115.
  - Allocate 116 -> replaces entry 0; fetch_pc=100 misses, 101 hits.
  - Allocate 117 -> replaces entry 1; vptr=2.
  - A not-taken miss at 200 -> no allocation, vptr still 2.
- Flush and reset:
  - flush with a simultaneous taken update pc=40 -> all lookups miss, 40 included; next allocation uses entry 0.
  - Drop reset low mid-cycle while pc=8 is trained -> pred_taken=0 at once, before any clock edge.

Source files
------------

// File: rtl/branch_target_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_target_predictor                                                    |
// | Fully-associative BTB with saturating direction counters; predicts the     |
// | first taken slot of a fetch group in the same cycle.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_target_predictor #(
  parameter int ENTRIES     = 16,
  parameter int FETCH_WIDTH = 2,
  parameter int ADDR_W      = 10,
  parameter int CTR_W       = 2,
  localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [SLOT_W-1:0] pred_slot,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
);

  localparam int               IDX_W       = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] c_CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] c_CTR_INIT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [IDX_W-1:0] c_VPTR_LAST = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] r_valid;
  logic [ADDR_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic [IDX_W-1:0]   r_vptr;

  logic [FETCH_WIDTH-1:0] w_slot_taken;
  logic [ADDR_W-1:0]      w_slot_target [FETCH_WIDTH];

  logic              w_pred_taken;
  logic [SLOT_W-1:0] w_pred_slot;
  logic [ADDR_W-1:0] w_pred_target;

  logic             w_upd_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_alloc_idx;

  // Tags are unique, so OR-ing targets of matching entries selects the single hit.
  genvar k;
  generate
    for (k = 0; k < FETCH_WIDTH; k++) begin : g_slot
      logic [ADDR_W-1:0] w_pc;
      logic              w_hit;
      logic [ADDR_W-1:0] w_tgt;

      assign w_pc = fetch_pc + ADDR_W'(k);

      always_comb begin
        w_hit = 1'b0;
        w_tgt = '0;
        for (int e = 0; e < ENTRIES; e++) begin
          if (r_valid[e] && (r_tag[e] == w_pc) && r_ctr[e][CTR_W-1]) begin
            w_hit = 1'b1;
            w_tgt = w_tgt | r_target[e];
          end
        end
      end

      assign w_slot_taken[k]  = w_hit;
      assign w_slot_target[k] = w_tgt;
    end
  endgenerate

  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_slot   = '0;
    w_pred_target = '0;
    if (fetch_valid) begin
      for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
        if (w_slot_taken[s]) begin
          w_pred_taken  = 1'b1;
          w_pred_slot   = SLOT_W'(s);
          w_pred_target = w_slot_target[s];
        end
      end
    end
  end

  assign pred_taken  = w_pred_taken;
  assign pred_slot   = w_pred_slot;
  assign pred_target = w_pred_target;

  // Descending scan leaves the lowest matching / lowest free index.
  always_comb begin
    w_upd_hit    = 1'b0;
    w_upd_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (r_valid[e] && (r_tag[e] == upd_pc)) begin
        w_upd_hit = 1'b1;
        w_upd_idx = IDX_W'(e);
      end
      if (!r_valid[e]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(e);
      end
    end
  end

  assign w_alloc_idx = w_free_found ? w_free_idx : r_vptr;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_vptr  <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        r_tag[e]    <= '0;
        r_target[e] <= '0;
        r_ctr[e]    <= c_CTR_INIT;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_vptr  <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_target[w_upd_idx] <= upd_target;
          if (r_ctr[w_upd_idx] != c_CTR_MAX) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + CTR_W'(1);
          end
        end else if (r_ctr[w_upd_idx] != '0) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        r_valid[w_alloc_idx]  <= 1'b1;
        r_tag[w_alloc_idx]    <= upd_pc;
        r_target[w_alloc_idx] <= upd_target;
        r_ctr[w_alloc_idx]    <= c_CTR_INIT;
        if (!w_free_found) begin
          r_vptr <= (r_vptr == c_VPTR_LAST) ? '0 : r_vptr + IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_target_predictor                                                 |
// | Directed stimulus with a scoreboard queue drained by a negedge monitor.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_target_predictor;

  localparam int AW = 10;
  localparam int SW = 1;

  logic          clk1;
  logic          reset;
  logic          fetch_valid;
  logic [AW-1:0] fetch_pc;
  logic          pred_taken;
  logic [SW-1:0] pred_slot;
  logic [AW-1:0] pred_target;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic          flush;

  typedef struct {
    int            id;
    logic          t;
    logic [SW-1:0] s;
    logic [AW-1:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req;
  int   n_issued;
  int   checks;
  int   errors;

  branch_target_predictor #(
    .ENTRIES(16), .FETCH_WIDTH(2), .ADDR_W(AW), .CTR_W(2)
  ) dut (
    .clk1(clk1), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush(flush)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  always @(negedge clk1) begin
    if (chk_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output present but no expectation queued");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (pred_taken !== e.t || pred_slot !== e.s || pred_target !== e.tgt) begin
          errors++;
          $display("FAIL pred#%0d: got taken=%0d slot=%0d target=%0d, expected taken=%0d slot=%0d target=%0d",
                   e.id, pred_taken, pred_slot, pred_target, e.t, e.s, e.tgt);
        end
      end
    end
  end

  task automatic step(input logic fv, input logic [AW-1:0] fpc,
                      input logic uv, input logic [AW-1:0] upc, input logic ut,
                      input logic [AW-1:0] utgt, input logic fl,
                      input logic chk, input logic et, input logic [SW-1:0] es,
                      input logic [AW-1:0] etgt);
    fetch_valid = fv;
    fetch_pc    = fpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    flush       = fl;
    if (chk) begin
      sb_q.push_back('{id: n_issued, t: et, s: es, tgt: etgt});
      n_issued++;
      chk_req = 1'b1;
    end
    @(posedge clk1);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt);
    step(1'b0, '0, 1'b1, pc, t, tgt, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic look(input logic [AW-1:0] pc, input logic t, input logic [SW-1:0] s,
                      input logic [AW-1:0] tgt);
    step(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, t, s, tgt);
  endtask

  initial begin
    chk_req = 1'b0; n_issued = 0; checks = 0; errors = 0;
    reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    reset = 1'b1;

    // Reset state and first training
    look(8, 0, 0, 0);
    upd(8, 1, 20);
    look(8, 1, 0, 20);
    look(7, 1, 1, 20);
    step(1'b0, 8, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Counter walk on pc 8 (ctr starts at 2)
    upd(8, 0, 0);  look(8, 0, 0, 0);
    upd(8, 0, 0);  look(8, 0, 0, 0);
    upd(8, 1, 20); look(8, 0, 0, 0);
    upd(8, 1, 20); look(8, 1, 0, 20);
    repeat (4) upd(8, 1, 20);
    upd(8, 0, 0);  look(8, 1, 0, 20);
    upd(8, 0, 0);  look(8, 0, 0, 0);
    upd(8, 1, 20); look(8, 1, 0, 20);

    // Back-to-back branches in one fetch group
    upd(9, 1, 18);
    look(8, 1, 0, 20);
    upd(8, 0, 0);
    upd(8, 0, 0);
    look(8, 1, 1, 18);
    upd(9, 1, 25);
    look(8, 1, 1, 25);
    upd(9, 0, 99);
    look(9, 1, 0, 25);
    // Same-cycle lookup and update sees the pre-update counter
    step(1'b1, 9, 1'b1, 9, 1'b0, '0, 1'b0, 1'b1, 1'b1, 0, 25);
    look(9, 0, 0, 0);
    // Slot 1 wraps from 1023 to 0
    upd(0, 1, 5);
    look(1023, 1, 1, 5);

    // Flush wins over a simultaneous update
    step(1'b0, '0, 1'b1, 40, 1'b1, 7, 1'b1, 1'b0, 1'b0, '0, '0);
    look(40, 0, 0, 0);
    look(8, 0, 0, 0);
    look(1023, 0, 0, 0);

    // Capacity and round-robin replacement
    for (int i = 0; i < 16; i++) upd(AW'(100 + i), 1, AW'(300 + i));
    look(100, 1, 0, 300);
    look(115, 1, 0, 315);
    upd(116, 1, 316);
    look(100, 1, 1, 301);
    look(116, 1, 0, 316);
    upd(117, 1, 317);
    look(101, 1, 1, 302);
    upd(200, 0, 0);
    look(200, 0, 0, 0);
    upd(118, 1, 318);
    look(102, 1, 1, 303);
    look(118, 1, 0, 318);

    // Flush resets the victim pointer; then it wraps from 15 to 0
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) upd(AW'(500 + i), 1, AW'(200 + i));
    upd(516, 1, 216);
    look(500, 1, 1, 201);
    for (int i = 17; i < 32; i++) upd(AW'(500 + i), 1, AW'(200 + i));
    upd(532, 1, 232);
    look(516, 1, 1, 217);
    look(531, 1, 0, 231);
    look(532, 1, 0, 232);

    // Asynchronous reset mid-cycle
    upd(8, 1, 20);
    look(8, 1, 0, 20);
    fetch_valid = 1'b1;
    fetch_pc    = 8;
    upd_valid   = 1'b0;
    #1;
    reset = 1'b0;
    sb_q.push_back('{id: n_issued, t: 1'b0, s: '0, tgt: '0});
    n_issued++;
    chk_req = 1'b1;
    @(posedge clk1);
    #1;
    chk_req = 1'b0;
    reset = 1'b1;
    look(8, 0, 0, 0);
    look(532, 0, 0, 0);

    @(posedge clk1);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
